// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port synchronous RAM between two masters
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   setn                enable; low blocks new grants (an in-flight access still completes)
//   mK_req/write/addr/wdata   master K request (K = 0 cpu data port, K = 1 loader/DMA port)
//   mK_gnt              one-cycle pulse while master K's access is presented to the RAM
//   mK_rvalid/rdata     one-cycle response pulse; rdata carries the RAM read data for reads, 0 otherwise
//   ram_sel/write/addr/wdata  registered RAM command
//   ram_rdata           RAM read data, valid the cycle after a read access
//
// Optional feature (macro MEM_ARB_LOCK_EN): adds m0_lock/m1_lock. A grant taken with lock = 1
// keeps the bus for that master (the other master is ineligible) until it is granted with lock = 0.
module mem_arbiter #(
    parameter int AMSB = 7,
    parameter int DMSB = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          setn,
    input  logic          m0_req,
    input  logic          m0_write,
    input  logic [AMSB:0] m0_addr,
    input  logic [DMSB:0] m0_wdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic          m0_lock,
    input  logic          m1_lock,
`endif
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DMSB:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_write,
    input  logic [AMSB:0] m1_addr,
    input  logic [DMSB:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DMSB:0] m1_rdata,
    output logic          ram_sel,
    output logic          ram_write,
    output logic [AMSB:0] ram_addr,
    output logic [DMSB:0] ram_wdata,
    input  logic [DMSB:0] ram_rdata
);
    typedef enum logic [1:0] {IDLE, ACC, RSP} state_t;
    state_t        state_q, state_d;
    logic          prio_q, prio_d;
    logic          owner_q, owner_d;
    logic          rd_q, rd_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic          sel_q, sel_d;
    logic          write_q, write_d;
    logic [AMSB:0] addr_q, addr_d;
    logic [DMSB:0] wdata_q, wdata_d;
    logic          elig0, elig1, win, win_write, grant;
`ifdef MEM_ARB_LOCK_EN
    logic          lock_q, lock_d;
    logic          lock_own_q, lock_own_d;
    logic          win_lock;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            owner_q    <= 1'b0;
            rd_q       <= 1'b0;
            gnt_q      <= '0;
            rvalid_q   <= '0;
            sel_q      <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef MEM_ARB_LOCK_EN
            lock_q     <= 1'b0;
            lock_own_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            owner_q    <= owner_d;
            rd_q       <= rd_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            sel_q      <= sel_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef MEM_ARB_LOCK_EN
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
`endif
        end
    end
    always_comb begin
`ifdef MEM_ARB_LOCK_EN
        // while a lock is held only its owner may compete
        elig0     = m0_req && !(lock_q && lock_own_q);
        elig1     = m1_req && !(lock_q && !lock_own_q);
`else
        elig0     = m0_req;
        elig1     = m1_req;
`endif
        win       = (elig0 && elig1) ? prio_q : elig1;
        win_write = win ? m1_write : m0_write;
        grant     = setn && (elig0 || elig1) && (state_q != ACC);
`ifdef MEM_ARB_LOCK_EN
        win_lock   = win ? m1_lock : m0_lock;
        lock_d     = lock_q;
        lock_own_d = lock_own_q;
`endif
        state_d  = IDLE;
        prio_d   = prio_q;
        owner_d  = owner_q;
        rd_d     = rd_q;
        gnt_d    = '0;
        rvalid_d = '0;
        sel_d    = 1'b0;
        write_d  = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        if (state_q == ACC) begin
            state_d  = RSP;
            rvalid_d = owner_q ? 2'b10 : 2'b01;
        end else if (grant) begin
            state_d = ACC;
            sel_d   = 1'b1;
            write_d = win_write;
            addr_d  = win ? m1_addr : m0_addr;
            wdata_d = win ? m1_wdata : m0_wdata;
            gnt_d   = win ? 2'b10 : 2'b01;
            owner_d = win;
            rd_d    = !win_write;
`ifdef MEM_ARB_LOCK_EN
            // a locked grant keeps priority where it is; an unlocked grant releases the lock
            prio_d     = win_lock ? prio_q : !win;
            lock_d     = win_lock;
            lock_own_d = win;
`else
            prio_d  = !win;
`endif
        end
    end
    assign m0_gnt    = gnt_q[0];
    assign m1_gnt    = gnt_q[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    // the RAM's read data only arrives during RSP, so it is steered by the registered response flags
    assign m0_rdata  = (rvalid_q[0] && rd_q) ? ram_rdata : '0;
    assign m1_rdata  = (rvalid_q[1] && rd_q) ? ram_rdata : '0;
    assign ram_sel   = sel_q;
    assign ram_write = write_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
endmodule
